// File: rtl/square_arbiter.sv
// Round-robin share of one square pipeline among REQUESTERS lanes; returns tagged results.
// Latency: grant to result_valid is LATENCY+2 cycles; no result backpressure, grant is the only flow control.
module square_arbiter #(
  parameter int VALUE_WIDTH = 12,
  parameter int REQUESTERS  = 4,
  parameter int LATENCY     = 3,
  parameter int TAG_WIDTH   = 2
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [REQUESTERS-1:0]              req,
  input  logic [REQUESTERS*VALUE_WIDTH-1:0]  req_value,
  output logic [REQUESTERS-1:0]              grant,
  output logic [VALUE_WIDTH-1:0]             sq_value,
  output logic                               sq_data_valid,
  input  logic [2*(VALUE_WIDTH-1)-1:0]       sq_square,
  input  logic                               sq_new_result,
  output logic [2*(VALUE_WIDTH-1)-1:0]       result,
  output logic [REQUESTERS-1:0]              result_valid,
  output logic [TAG_WIDTH-1:0]               result_tag,
  output logic                               protocol_error
);

  localparam int BW = $clog2(LATENCY + 1);

  logic [TAG_WIDTH-1:0]   last;
  logic [TAG_WIDTH-1:0]   grant_idx;
  logic                   grant_any;
  logic [VALUE_WIDTH-1:0] sel_value;
  logic [BW-1:0]          blank_cnt;
  logic [REQUESTERS-1:0]  tag_onehot;

  // Stage 0 is written alongside sq_data_valid; stage LATENCY lines up with sq_new_result.
  logic                 tag_vld [0:LATENCY];
  logic [TAG_WIDTH-1:0] tag_dat [0:LATENCY];

  // Two passes: lanes above the pointer first, then wrap to lanes at or below it.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    sel_value = '0;
    if (!reset) begin
      for (int i = 0; i < REQUESTERS; i++) begin
        if (!grant_any && req[i] && (TAG_WIDTH'(i) > last)) begin
          grant_any = 1'b1;
          grant_idx = TAG_WIDTH'(i);
        end
      end
      for (int i = 0; i < REQUESTERS; i++) begin
        if (!grant_any && req[i] && (TAG_WIDTH'(i) <= last)) begin
          grant_any = 1'b1;
          grant_idx = TAG_WIDTH'(i);
        end
      end
    end
    for (int i = 0; i < REQUESTERS; i++) begin
      if (grant_any && (grant_idx == TAG_WIDTH'(i))) begin
        grant[i]  = 1'b1;
        sel_value = req_value[i*VALUE_WIDTH +: VALUE_WIDTH];
      end
    end
  end

  always_comb begin
    tag_onehot = '0;
    for (int i = 0; i < REQUESTERS; i++) begin
      if (tag_dat[LATENCY] == TAG_WIDTH'(i)) tag_onehot[i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last          <= TAG_WIDTH'(REQUESTERS - 1);
      sq_value      <= '0;
      sq_data_valid <= 1'b0;
    end else begin
      sq_data_valid <= grant_any;
      if (grant_any) begin
        last     <= grant_idx;
        sq_value <= sel_value;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s <= LATENCY; s++) begin
        tag_vld[s] <= 1'b0;
        tag_dat[s] <= '0;
      end
    end else begin
      tag_vld[0] <= grant_any;
      tag_dat[0] <= grant_idx;
      for (int s = 1; s <= LATENCY; s++) begin
        tag_vld[s] <= tag_vld[s-1];
        tag_dat[s] <= tag_dat[s-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result       <= '0;
      result_valid <= '0;
      result_tag   <= '0;
    end else begin
      result <= sq_square;
      if (tag_vld[LATENCY]) begin
        result_valid <= tag_onehot;
        result_tag   <= tag_dat[LATENCY];
      end else begin
        result_valid <= '0;
      end
    end
  end

  // The square unit restarts with us, so its output is meaningless until the pipe refills.
  always_ff @(posedge clk) begin
    if (reset) begin
      blank_cnt      <= BW'(LATENCY);
      protocol_error <= 1'b0;
    end else begin
      if (blank_cnt != '0) begin
        blank_cnt <= blank_cnt - BW'(1);
      end else if (sq_new_result != tag_vld[LATENCY]) begin
        protocol_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_square_arbiter.sv
// Directed bench for square_arbiter with a behavioural 3-stage square unit attached.
module tb_square_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [47:0] req_value;
  logic [3:0]  grant;
  logic [11:0] sq_value;
  logic        sq_data_valid;
  logic [21:0] sq_square;
  logic        sq_new_result;
  logic [21:0] result;
  logic [3:0]  result_valid;
  logic [1:0]  result_tag;
  logic        protocol_error;
  logic        force_nr;

  int tests = 0;
  int fails = 0;

  logic [21:0] m_sq [0:2];
  logic        m_v  [0:2];

  always #5 clk = ~clk;

  square_arbiter #(.VALUE_WIDTH(12), .REQUESTERS(4), .LATENCY(3), .TAG_WIDTH(2)) dut (
    .clk(clk), .reset(reset), .req(req), .req_value(req_value), .grant(grant),
    .sq_value(sq_value), .sq_data_valid(sq_data_valid), .sq_square(sq_square),
    .sq_new_result(sq_new_result), .result(result), .result_valid(result_valid),
    .result_tag(result_tag), .protocol_error(protocol_error)
  );

  always @(posedge clk) begin
    int s;
    s = int'($signed(sq_value));
    if (reset) begin
      for (int k = 0; k < 3; k++) begin
        m_v[k]  <= 1'b0;
        m_sq[k] <= '0;
      end
    end else begin
      m_v[0]  <= sq_data_valid;
      m_sq[0] <= 22'(s * s);
      m_v[1]  <= m_v[0];
      m_sq[1] <= m_sq[0];
      m_v[2]  <= m_v[1];
      m_sq[2] <= m_sq[1];
    end
  end

  assign sq_square     = m_sq[2];
  assign sq_new_result = m_v[2] | force_nr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_val(input int lane, input int value);
    req_value[lane*12 +: 12] = 12'(value);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Expected per-lane squares for the continuous test (values 100,-200,300,-4).
  logic [21:0] cont_sq [0:3];
  logic [3:0]  exp_v;

  initial begin
    cont_sq[0] = 22'd10000;
    cont_sq[1] = 22'd40000;
    cont_sq[2] = 22'd90000;
    cont_sq[3] = 22'd16;
    force_nr  = 1'b0;
    req_value = '0;
    reset     = 1'b1;
    req       = 4'b1111;
    tick();
    tick();
    #1;
    chk("reset_grant", 32'(grant), 32'd0);
    chk("reset_sq_dv", 32'(sq_data_valid), 32'd0);
    chk("reset_sq_value", 32'(sq_value), 32'd0);
    chk("reset_result", 32'(result), 32'd0);
    chk("reset_rvalid", 32'(result_valid), 32'd0);
    chk("reset_tag", 32'(result_tag), 32'd0);
    chk("reset_perr", 32'(protocol_error), 32'd0);
    req   = '0;
    reset = 1'b0;
    tick();

    // Single request: lane 2, -1500. Priority starts at lane 0 but only lane 2 asks.
    set_val(2, -1500);
    req = 4'b0100;
    #1;
    chk("single_grant", 32'(grant), 32'h4);
    tick();
    req = '0;
    chk("single_sq_dv", 32'(sq_data_valid), 32'd1);
    chk("single_sq_value", 32'(sq_value), 32'(12'hA24));
    for (int c = 1; c < 5; c++) begin
      chk("single_quiet", 32'(result_valid), 32'd0);
      tick();
    end
    chk("single_rvalid", 32'(result_valid), 32'h4);
    chk("single_result", 32'(result), 32'd2250000);
    chk("single_tag", 32'(result_tag), 32'd2);
    tick();
    chk("single_after", 32'(result_valid), 32'd0);

    // All lanes continuous for 8 cycles.
    do_reset();
    set_val(0, 100);
    set_val(1, -200);
    set_val(2, 300);
    set_val(3, -4);
    for (int c = 0; c < 14; c++) begin
      req = (c < 8) ? 4'b1111 : 4'b0000;
      #1;
      if (c < 8) chk("cont_grant", 32'(grant), 32'(1 << (c % 4)));
      else chk("cont_nogrant", 32'(grant), 32'd0);
      if (c >= 5 && c < 13) begin
        chk("cont_rvalid", 32'(result_valid), 32'(1 << ((c - 5) % 4)));
        chk("cont_result", 32'(result), 32'(cont_sq[(c - 5) % 4]));
        chk("cont_tag", 32'(result_tag), 32'((c - 5) % 4));
      end else begin
        chk("cont_quiet", 32'(result_valid), 32'd0);
      end
      tick();
    end

    // Sparse: lanes 1 (value 0) and 3 (value +1500).
    do_reset();
    set_val(1, 0);
    set_val(3, 1500);
    for (int c = 0; c < 10; c++) begin
      req = (c < 4) ? 4'b1010 : 4'b0000;
      #1;
      if (c < 4) chk("sparse_grant", 32'(grant), (c % 2 == 0) ? 32'h2 : 32'h8);
      if (c >= 5 && c < 9) begin
        exp_v = (c % 2 == 1) ? 4'b0010 : 4'b1000;
        chk("sparse_rvalid", 32'(result_valid), 32'(exp_v));
        chk("sparse_result", 32'(result), (c % 2 == 1) ? 32'd0 : 32'd2250000);
      end else begin
        chk("sparse_quiet", 32'(result_valid), 32'd0);
      end
      tick();
    end

    // Boundary -1 on lane 0.
    set_val(0, -1);
    req = 4'b0001;
    #1;
    chk("neg1_grant", 32'(grant), 32'h1);
    tick();
    req = '0;
    for (int c = 1; c < 5; c++) tick();
    chk("neg1_rvalid", 32'(result_valid), 32'h1);
    chk("neg1_result", 32'(result), 32'd1);
    chk("neg1_tag", 32'(result_tag), 32'd0);
    chk("perr_before", 32'(protocol_error), 32'd0);

    // Protocol mismatch: spurious new_result with the pipe empty.
    tick();
    tick();
    force_nr = 1'b1;
    tick();
    force_nr = 1'b0;
    chk("perr_rise", 32'(protocol_error), 32'd1);
    tick();
    tick();
    tick();
    chk("perr_sticky", 32'(protocol_error), 32'd1);
    do_reset();
    chk("perr_cleared", 32'(protocol_error), 32'd0);

    // Reset mid-flight: three grants, one idle cycle, then reset.
    set_val(0, 7);
    set_val(1, 8);
    set_val(2, 9);
    for (int c = 0; c < 3; c++) begin
      req = 4'b0111;
      #1;
      chk("mid_grant", 32'(grant), 32'(1 << c));
      tick();
    end
    req = '0;
    tick();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      chk("mid_quiet", 32'(result_valid), 32'd0);
      tick();
    end
    chk("mid_perr", 32'(protocol_error), 32'd0);
    req = 4'b1111;
    #1;
    chk("mid_first_lane0", 32'(grant), 32'h1);
    tick();
    req = '0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
